// File: rtl/aes_cbc_pkcs7_pad.sv
// rtl/aes_cbc_pkcs7_pad.sv - AXI-Stream PKCS#7 padding front end for aes256_cbc_comb
module aes_cbc_pkcs7_pad #(
  parameter int AXIS_WIDTH = 64
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [AXIS_WIDTH-1:0]   S_axis_tdata,
  input  logic [AXIS_WIDTH/8-1:0] S_axis_tkeep,
  input  logic                    S_axis_tvalid,
  output logic                    S_axis_tready,
  input  logic                    S_axis_tlast,
  input  logic                    S_axis_tuser,
  output logic [AXIS_WIDTH-1:0]   M_axis_tdata,
  output logic [AXIS_WIDTH/8-1:0] M_axis_tkeep,
  output logic                    M_axis_tvalid,
  input  logic                    M_axis_tready,
  output logic                    M_axis_tlast,
  output logic                    M_axis_tuser,
  output logic                    Align_err
);

  localparam int BYTES     = AXIS_WIDTH / 8;
  localparam int HDR_WORDS = 384 / AXIS_WIDTH;
  localparam int HCW       = $clog2(HDR_WORDS);
  localparam logic [4:0]     BYTES5   = 5'(BYTES);
  localparam logic [HCW-1:0] HDR_LAST = HCW'(HDR_WORDS - 1);

  typedef enum logic [1:0] {ST_HDR, ST_PAY, ST_PAD} state_t;

  state_t         state, state_nxt;
  logic [HCW-1:0] hdr_cnt, hdr_cnt_nxt;
  logic [3:0]     byte_cnt, byte_cnt_nxt;
  logic [4:0]     pad_val, pad_val_nxt;
  logic           mode, mode_nxt;

  logic                  load_en, accept;
  logic [4:0]            n, sum5, full5, pad_p;
  logic                  blk_done, enc_last_done, run;
  logic                  emit, beat_last, beat_user, beat_err;
  logic [AXIS_WIDTH-1:0] beat_data;

  assign load_en       = ~M_axis_tvalid | M_axis_tready;
  assign S_axis_tready = ~Rst & load_en & (state != ST_PAD);
  assign accept        = S_axis_tvalid & S_axis_tready;

  // n = run length of valid lanes starting at lane 0; lanes above the first hole are ignored
  always_comb begin
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < BYTES; i++) begin
      if (run && S_axis_tkeep[i]) n = n + 5'd1;
      else                        run = 1'b0;
    end
  end

  assign sum5     = {1'b0, byte_cnt} + n;
  assign pad_p    = 5'd16 - {1'b0, sum5[3:0]};
  assign full5    = {1'b0, byte_cnt} + BYTES5;
  assign blk_done = (full5[3:0] == 4'd0);
  // a beat with n==0 carries the start of a fresh pad block, so it may close that block itself
  assign enc_last_done = blk_done & ((pad_p != 5'd16) | (n == 5'd0));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_HDR;
      hdr_cnt  <= '0;
      byte_cnt <= '0;
      pad_val  <= '0;
      mode     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hdr_cnt  <= hdr_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      pad_val  <= pad_val_nxt;
      mode     <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hdr_cnt_nxt  = hdr_cnt;
    byte_cnt_nxt = byte_cnt;
    pad_val_nxt  = pad_val;
    mode_nxt     = mode;
    case (state)
      ST_HDR: if (accept) begin
        if (hdr_cnt == '0) mode_nxt = S_axis_tuser;
        if (hdr_cnt == HDR_LAST) begin
          hdr_cnt_nxt  = '0;
          byte_cnt_nxt = '0;
          state_nxt    = ST_PAY;
        end else begin
          hdr_cnt_nxt = hdr_cnt + 1'b1;
        end
      end
      ST_PAY: if (accept) begin
        byte_cnt_nxt = full5[3:0];
        if (S_axis_tlast) begin
          if (!mode || enc_last_done) begin
            state_nxt = ST_HDR;
          end else begin
            state_nxt   = ST_PAD;
            pad_val_nxt = pad_p;
          end
        end
      end
      ST_PAD: if (load_en) begin
        byte_cnt_nxt = full5[3:0];
        if (blk_done) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    beat_data = S_axis_tdata;
    beat_last = 1'b0;
    beat_user = mode;
    beat_err  = 1'b0;
    case (state)
      ST_HDR: begin
        emit      = accept;
        beat_user = (hdr_cnt == '0) ? S_axis_tuser : mode;
      end
      ST_PAY: begin
        emit      = accept;
        beat_last = S_axis_tlast;
        if (S_axis_tlast) begin
          if (mode) begin
            for (int i = 0; i < BYTES; i++)
              if (5'(i) >= n) beat_data[8*i +: 8] = {3'b000, pad_p};
            beat_last = enc_last_done;
          end else begin
            beat_err = (sum5[3:0] != 4'd0) | (n != BYTES5);
          end
        end
      end
      ST_PAD: begin
        emit      = load_en;
        beat_data = {BYTES{3'b000, pad_val}};
        beat_last = blk_done;
      end
      default: emit = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      M_axis_tvalid <= 1'b0;
      M_axis_tdata  <= '0;
      M_axis_tkeep  <= '0;
      M_axis_tlast  <= 1'b0;
      M_axis_tuser  <= 1'b0;
      Align_err     <= 1'b0;
    end else begin
      Align_err <= emit & beat_err;
      if (load_en) begin
        M_axis_tvalid <= emit;
        if (emit) begin
          M_axis_tdata <= beat_data;
          M_axis_tkeep <= '1;
          M_axis_tlast <= beat_last;
          M_axis_tuser <= beat_user;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_cbc_pkcs7_pad.sv
// tb/tb_aes_cbc_pkcs7_pad.sv - directed self-checking bench for aes_cbc_pkcs7_pad
module tb_aes_cbc_pkcs7_pad;
  localparam int W = 64;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [W-1:0] S_axis_tdata = '0;
  logic [7:0]   S_axis_tkeep = '0;
  logic         S_axis_tvalid = 1'b0;
  logic         S_axis_tready;
  logic         S_axis_tlast = 1'b0;
  logic         S_axis_tuser = 1'b0;
  logic [W-1:0] M_axis_tdata;
  logic [7:0]   M_axis_tkeep;
  logic         M_axis_tvalid;
  logic         M_axis_tready = 1'b0;
  logic         M_axis_tlast;
  logic         M_axis_tuser;
  logic         Align_err;

  always #5 Clk = ~Clk;

  aes_cbc_pkcs7_pad #(.AXIS_WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst),
    .S_axis_tdata(S_axis_tdata), .S_axis_tkeep(S_axis_tkeep), .S_axis_tvalid(S_axis_tvalid),
    .S_axis_tready(S_axis_tready), .S_axis_tlast(S_axis_tlast), .S_axis_tuser(S_axis_tuser),
    .M_axis_tdata(M_axis_tdata), .M_axis_tkeep(M_axis_tkeep), .M_axis_tvalid(M_axis_tvalid),
    .M_axis_tready(M_axis_tready), .M_axis_tlast(M_axis_tlast), .M_axis_tuser(M_axis_tuser),
    .Align_err(Align_err)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  beat_t out_q[$];
  int    checks = 0;
  int    failures = 0;
  int    err_pulses = 0;
  int    stall_viol = 0;
  int    timeouts = 0;
  bit    gaps = 1'b0;
  bit    hold_prev = 1'b0;
  beat_t held;

  // output monitor: handshakes, Align_err pulses, and stability of a stalled beat
  always @(negedge Clk) begin
    if (Rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (Align_err) err_pulses++;
      if (hold_prev && ({M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser} != held))
        stall_viol++;
      if (M_axis_tvalid && M_axis_tready)
        out_q.push_back('{M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser});
      hold_prev <= M_axis_tvalid && !M_axis_tready;
      held      <= '{M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] hdr_word(input int i);
    logic [63:0] base;
    base = 64'hA5A5_0000_0000_0000;
    return base + 64'(i * 64'h0101_0101);
  endfunction

  task automatic add_hdr(input bit u, input bit stray_last);
    for (int i = 0; i < 6; i++) begin
      in_q.push_back('{hdr_word(i), 8'hFF, stray_last && (i == 2), u});
      exp_q.push_back('{hdr_word(i), 8'hFF, 1'b0, u});
    end
  endtask

  task automatic build_t1();
    add_hdr(1'b1, 1'b1);
    in_q.push_back('{64'hDEADBEEF_EECCBBAA, 8'h07, 1'b1, 1'b1});
    exp_q.push_back('{64'h0D0D0D0D_0DCCBBAA, 8'hFF, 1'b0, 1'b1});
    exp_q.push_back('{64'h0D0D0D0D_0D0D0D0D, 8'hFF, 1'b1, 1'b1});
  endtask

  task automatic build_t2();
    add_hdr(1'b1, 1'b0);
    in_q.push_back('{64'h07060504_03020100, 8'hFF, 1'b0, 1'b1});
    in_q.push_back('{64'h0F0E0D0C_0B0A0908, 8'hFF, 1'b1, 1'b1});
    exp_q.push_back('{64'h07060504_03020100, 8'hFF, 1'b0, 1'b1});
    exp_q.push_back('{64'h0F0E0D0C_0B0A0908, 8'hFF, 1'b0, 1'b1});
    exp_q.push_back('{64'h10101010_10101010, 8'hFF, 1'b0, 1'b1});
    exp_q.push_back('{64'h10101010_10101010, 8'hFF, 1'b1, 1'b1});
  endtask

  task automatic build_t3();
    add_hdr(1'b1, 1'b0);
    in_q.push_back('{64'h07060504_03020100, 8'hFF, 1'b0, 1'b1});
    in_q.push_back('{64'hFF0E0D0C_0B0A0908, 8'h7F, 1'b1, 1'b1});
    exp_q.push_back('{64'h07060504_03020100, 8'hFF, 1'b0, 1'b1});
    exp_q.push_back('{64'h010E0D0C_0B0A0908, 8'hFF, 1'b1, 1'b1});
  endtask

  task automatic run_pkt(input string name);
    int cyc;
    out_q.delete();
    timeouts = 0;
    fork
      begin
        foreach (in_q[j]) begin
          bit acc;
          int to;
          if (gaps) repeat ($urandom_range(0, 1)) begin
            S_axis_tvalid = 1'b0;
            @(posedge Clk); #1;
          end
          S_axis_tdata  = in_q[j].d;
          S_axis_tkeep  = in_q[j].k;
          S_axis_tlast  = in_q[j].l;
          S_axis_tuser  = in_q[j].u;
          S_axis_tvalid = 1'b1;
          acc = 1'b0;
          to  = 0;
          while (!acc && to < 200) begin
            @(negedge Clk);
            acc = S_axis_tready;
            @(posedge Clk); #1;
            to++;
          end
          if (!acc) timeouts++;
        end
        S_axis_tvalid = 1'b0;
      end
      begin
        cyc = 0;
        while (out_q.size() < exp_q.size() && cyc < 800) begin
          M_axis_tready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          @(posedge Clk); #1;
          cyc++;
        end
        M_axis_tready = 1'b1;
      end
    join
    repeat (3) begin
      @(posedge Clk); #1;
    end
    chk({name, "_timeouts"}, 64'(timeouts), 64'd0);
    chk({name, "_beats"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk($sformatf("%s_b%0d_data", name, i), out_q[i].d, exp_q[i].d);
      chk($sformatf("%s_b%0d_keep", name, i), 64'(out_q[i].k), 64'(exp_q[i].k));
      chk($sformatf("%s_b%0d_last", name, i), 64'(out_q[i].l), 64'(exp_q[i].l));
      chk($sformatf("%s_b%0d_user", name, i), 64'(out_q[i].u), 64'(exp_q[i].u));
    end
    in_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) begin
      @(posedge Clk); #1;
    end
    chk("rst_tvalid", 64'(M_axis_tvalid), 64'd0);
    chk("rst_tdata", M_axis_tdata, 64'd0);
    chk("rst_tkeep", 64'(M_axis_tkeep), 64'd0);
    chk("rst_tlast", 64'(M_axis_tlast), 64'd0);
    chk("rst_tuser", 64'(M_axis_tuser), 64'd0);
    chk("rst_align", 64'(Align_err), 64'd0);
    chk("rst_s_tready", 64'(S_axis_tready), 64'd0);
    Rst = 1'b0;
    M_axis_tready = 1'b1;
    @(posedge Clk); #1;

    build_t1(); run_pkt("t1");
    build_t2(); run_pkt("t2");
    build_t3(); run_pkt("t3");

    err_pulses = 0;
    add_hdr(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] d;
      d = 64'h0123_4567_89AB_CDEF ^ 64'(i * 64'h1111_0000_2222);
      in_q.push_back('{d, 8'hFF, i == 3, 1'b0});
      exp_q.push_back('{d, 8'hFF, i == 3, 1'b0});
    end
    run_pkt("t4_dec32");
    chk("t4_dec32_align", 64'(err_pulses), 64'd0);

    err_pulses = 0;
    add_hdr(1'b0, 1'b0);
    in_q.push_back('{64'h11223344_55667788, 8'h0F, 1'b1, 1'b0});
    exp_q.push_back('{64'h11223344_55667788, 8'hFF, 1'b1, 1'b0});
    run_pkt("t4_misalign");
    chk("t4_misalign_align", 64'(err_pulses), 64'd1);

    add_hdr(1'b1, 1'b0);
    in_q.push_back('{64'h12345678_9ABCDEF0, 8'h00, 1'b1, 1'b1});
    exp_q.push_back('{64'h10101010_10101010, 8'hFF, 1'b0, 1'b1});
    exp_q.push_back('{64'h10101010_10101010, 8'hFF, 1'b1, 1'b1});
    run_pkt("empty");

    gaps = 1'b1;
    stall_viol = 0;
    build_t1(); run_pkt("t5_t1");
    build_t2(); run_pkt("t5_t2");
    build_t3(); run_pkt("t5_t3");
    chk("t5_stall_stable", 64'(stall_viol), 64'd0);
    gaps = 1'b0;

    // drive T1 by hand and freeze the output so the block sits in its pad state
    M_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      S_axis_tdata = hdr_word(i); S_axis_tkeep = 8'hFF;
      S_axis_tlast = 1'b0; S_axis_tuser = 1'b1; S_axis_tvalid = 1'b1;
      @(posedge Clk); #1;
    end
    S_axis_tdata = 64'hDEADBEEF_EECCBBAA; S_axis_tkeep = 8'h07; S_axis_tlast = 1'b1;
    @(posedge Clk); #1;
    S_axis_tvalid = 1'b0;
    M_axis_tready = 1'b0;
    @(posedge Clk); #1;
    chk("t6_pad_s_tready", 64'(S_axis_tready), 64'd0);
    chk("t6_pad_tvalid", 64'(M_axis_tvalid), 64'd1);
    chk("t6_pad_held", M_axis_tdata, 64'h0D0D0D0D_0DCCBBAA);
    Rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 64'(M_axis_tvalid), 64'd0);
    chk("t6_rst_tdata", M_axis_tdata, 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    M_axis_tready = 1'b1;
    @(posedge Clk); #1;
    build_t2(); run_pkt("t6_t2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
